// File: rtl/fallback_host_agent_if.sv
// Handshake bundle between the fallback host agent and its neighbours.
// master: agent side (pop, dispatch, resolve); slave: queue/engine/HDU side.
`ifndef HDU_FUNC_ID_WIDTH
`define HDU_FUNC_ID_WIDTH 16
`endif

interface fallback_host_agent_if #(
    parameter int AW = 2
);
    localparam int FW = `HDU_FUNC_ID_WIDTH;

    // fallback IRQ queue
    logic          irq_valid;
    logic [63:0]   irq_data;
    logic          host_ready;

    // dispatch request to the software-fallback engine
    logic          disp_valid;
    logic          disp_ready;
    logic [FW-1:0] disp_func_id;
    logic [47:0]   disp_token;
    logic [AW-1:0] disp_attempt;

    // completion from the engine
    logic          cpl_valid;
    logic          cpl_ok;

    // resolution back to the HDU
    logic          rsv_valid;
    logic          rsv_ready;
    logic [FW-1:0] rsv_func_id;
    logic [47:0]   rsv_token;
    logic [1:0]    rsv_status;

    modport master (
        input  irq_valid, irq_data,
        output host_ready,
        output disp_valid, disp_func_id, disp_token, disp_attempt,
        input  disp_ready,
        input  cpl_valid, cpl_ok,
        output rsv_valid, rsv_func_id, rsv_token, rsv_status,
        input  rsv_ready
    );

    modport slave (
        output irq_valid, irq_data,
        input  host_ready,
        input  disp_valid, disp_func_id, disp_token, disp_attempt,
        output disp_ready,
        output cpl_valid, cpl_ok,
        input  rsv_valid, rsv_func_id, rsv_token, rsv_status,
        output rsv_ready
    );
endinterface

// File: rtl/fallback_host_agent.sv
// Host-side consumer of the HDU fallback IRQ queue: pops one failure record,
// dispatches it to the software-fallback engine with retries, and resolves it.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   bus (master)  irq pop, dispatch request, completion, resolution
//   busy          agent is handling a record (state != IDLE)
//   ok_cnt        saturating count of ok resolutions
//   err_cnt       saturating count of fail/timeout resolutions
`ifndef HDU_FUNC_ID_WIDTH
`define HDU_FUNC_ID_WIDTH 16
`endif

module fallback_host_agent #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 2,
    parameter int CNT_W          = 16,
    localparam int AW            = $clog2(MAX_RETRY + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fallback_host_agent_if.master bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     ok_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int FW = `HDU_FUNC_ID_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_FAIL = 2'b01;
    localparam logic [1:0] ST_TMO  = 2'b10;

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] RETRY_MAX = AW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CAPTURE,
        S_DISPATCH,
        S_WAIT_CPL,
        S_RESOLVE
    } state_t;

    state_t           r_state;
    logic             r_host_ready;
    logic             r_disp_valid;
    logic             r_rsv_valid;
    logic [1:0]       r_rsv_status;
    logic [FW-1:0]    r_func_id;
    logic [47:0]      r_token;
    logic [AW-1:0]    r_attempt;
    logic [TW-1:0]    r_timer;
    logic [CNT_W-1:0] r_ok_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_host_ready <= 1'b0;
            r_disp_valid <= 1'b0;
            r_rsv_valid  <= 1'b0;
            r_rsv_status <= 2'b00;
            r_func_id    <= '0;
            r_token      <= '0;
            r_attempt    <= '0;
            r_timer      <= '0;
            r_ok_cnt     <= '0;
            r_err_cnt    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.irq_valid) begin
                        r_host_ready <= 1'b1;
                        r_state      <= S_POP;
                    end
                end

                // single-cycle pop strobe; queue presents data next cycle
                S_POP: begin
                    r_host_ready <= 1'b0;
                    r_state      <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    r_func_id    <= FW'(bus.irq_data[63:48]);
                    r_token      <= bus.irq_data[47:0];
                    r_attempt    <= '0;
                    r_disp_valid <= 1'b1;
                    r_state      <= S_DISPATCH;
                end

                S_DISPATCH: begin
                    if (bus.disp_ready) begin
                        r_disp_valid <= 1'b0;
                        r_timer      <= '0;
                        r_state      <= S_WAIT_CPL;
                    end
                end

                // a completion on the last timer cycle takes priority
                S_WAIT_CPL: begin
                    r_timer <= r_timer + 1'b1;
                    if (bus.cpl_valid && bus.cpl_ok) begin
                        r_rsv_status <= ST_OK;
                        r_rsv_valid  <= 1'b1;
                        r_state      <= S_RESOLVE;
                    end else if (bus.cpl_valid) begin
                        if (r_attempt < RETRY_MAX) begin
                            r_attempt    <= r_attempt + 1'b1;
                            r_disp_valid <= 1'b1;
                            r_state      <= S_DISPATCH;
                        end else begin
                            r_rsv_status <= ST_FAIL;
                            r_rsv_valid  <= 1'b1;
                            r_state      <= S_RESOLVE;
                        end
                    end else if (r_timer == TMO_LAST) begin
                        r_rsv_status <= ST_TMO;
                        r_rsv_valid  <= 1'b1;
                        r_state      <= S_RESOLVE;
                    end
                end

                S_RESOLVE: begin
                    if (bus.rsv_ready) begin
                        r_rsv_valid <= 1'b0;
                        r_state     <= S_IDLE;
                        if (r_rsv_status == ST_OK) begin
                            if (r_ok_cnt != '1) begin
                                r_ok_cnt <= r_ok_cnt + 1'b1;
                            end
                        end else begin
                            if (r_err_cnt != '1) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    r_host_ready <= 1'b0;
                    r_disp_valid <= 1'b0;
                    r_rsv_valid  <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // payload registers feed both the dispatch and resolution buses
    assign bus.host_ready   = r_host_ready;
    assign bus.disp_valid   = r_disp_valid;
    assign bus.disp_func_id = r_func_id;
    assign bus.disp_token   = r_token;
    assign bus.disp_attempt = r_attempt;
    assign bus.rsv_valid    = r_rsv_valid;
    assign bus.rsv_func_id  = r_func_id;
    assign bus.rsv_token    = r_token;
    assign bus.rsv_status   = r_rsv_status;

    assign busy    = (r_state != S_IDLE);
    assign ok_cnt  = r_ok_cnt;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_fallback_host_agent.sv
// Directed bench for fallback_host_agent (TIMEOUT_CYCLES=8, MAX_RETRY=2,
// CNT_W=2); a small queue model serves records in pop order.
module tb_fallback_host_agent;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [1:0] ok_cnt;
    logic [1:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int pops  = 0;
    int n;

    logic [63:0] recs [0:15];
    logic [63:0] snap;

    fallback_host_agent_if #(.AW(2)) bus_if ();

    fallback_host_agent #(
        .TIMEOUT_CYCLES(8),
        .MAX_RETRY(2),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus_if),
        .busy(busy),
        .ok_cnt(ok_cnt),
        .err_cnt(err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // queue model: a pop presents the next record for the following cycle
    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.host_ready === 1'b1) begin
                if (pops < 16) bus_if.irq_data = recs[pops];
                pops++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_disp(input string tag);
        for (int i = 0; i < 40 && bus_if.disp_valid !== 1'b1; i++) tick();
        chk(tag, 64'(bus_if.disp_valid), 64'd1);
    endtask

    task automatic cpl(input logic ok);
        bus_if.cpl_valid = 1'b1;
        bus_if.cpl_ok    = ok;
        tick();
        bus_if.cpl_valid = 1'b0;
        bus_if.cpl_ok    = 1'b0;
    endtask

    task automatic rsv_take();
        bus_if.rsv_ready = 1'b1;
        tick();
        bus_if.rsv_ready = 1'b0;
    endtask

    task automatic run_ok(input string tag, input logic [63:0] rec);
        bus_if.irq_valid = 1'b1;
        tick();
        bus_if.irq_valid = 1'b0;
        wait_disp({tag, "_disp"});
        tick();
        cpl(1'b1);
        chk({tag, "_rsv_valid"}, 64'(bus_if.rsv_valid), 64'd1);
        chk({tag, "_rsv_rec"},
            {bus_if.rsv_func_id, bus_if.rsv_token}, rec);
        chk({tag, "_rsv_status"}, 64'(bus_if.rsv_status), 64'd0);
        rsv_take();
        chk({tag, "_rsv_done"}, 64'(bus_if.rsv_valid), 64'd0);
    endtask

    initial begin
        recs[0]  = 64'h0042_0000_0000_1234;
        recs[1]  = 64'h0007_0000_0000_00AA;
        recs[2]  = 64'h0003_0000_0000_0003;
        recs[3]  = 64'h0004_0000_0000_0004;
        recs[4]  = 64'h0101_0000_0000_0A01;
        recs[5]  = 64'h0202_0000_0000_0B02;
        recs[6]  = 64'h0303_0000_0000_0C03;
        recs[7]  = 64'h0055_0000_0000_0055;
        recs[8]  = 64'h0066_0000_0000_0006;
        recs[9]  = 64'h0901_0000_0000_0009;
        recs[10] = 64'h0A02_0000_0000_000A;
        recs[11] = 64'h0B03_0000_0000_000B;
        recs[12] = 64'h0C04_0000_0000_000C;
        recs[13] = 64'h0;
        recs[14] = 64'h0;
        recs[15] = 64'h0;

        rst_n            = 1'b0;
        bus_if.irq_valid = 1'b0;
        bus_if.irq_data  = 64'h0;
        bus_if.disp_ready = 1'b1;
        bus_if.cpl_valid = 1'b0;
        bus_if.cpl_ok    = 1'b0;
        bus_if.rsv_ready = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_outs",
            {bus_if.host_ready, bus_if.disp_valid, bus_if.rsv_valid,
             busy, ok_cnt, err_cnt, bus_if.rsv_status}, 64'd0);
        chk("rst_payload", {bus_if.disp_func_id, bus_if.disp_token}, 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: single ok record, latency cycle 0 -> 3
        bus_if.irq_valid = 1'b1;
        chk("t1_c0_host_ready", 64'(bus_if.host_ready), 64'd0);
        tick();
        bus_if.irq_valid = 1'b0;
        chk("t1_c1_host_ready", 64'(bus_if.host_ready), 64'd1);
        chk("t1_c1_busy", 64'(busy), 64'd1);
        tick();
        chk("t1_c2_host_ready", 64'(bus_if.host_ready), 64'd0);
        chk("t1_c2_disp_valid", 64'(bus_if.disp_valid), 64'd0);
        tick();
        chk("t1_c3_disp_valid", 64'(bus_if.disp_valid), 64'd1);
        chk("t1_c3_func", 64'(bus_if.disp_func_id), 64'h42);
        chk("t1_c3_token", 64'(bus_if.disp_token), 64'h1234);
        chk("t1_c3_attempt", 64'(bus_if.disp_attempt), 64'd0);
        chk("t1_pops", 64'(pops), 64'd1);
        tick();
        chk("t1_disp_drop", 64'(bus_if.disp_valid), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("t1_no_rsv_yet", 64'(bus_if.rsv_valid), 64'd0);
        cpl(1'b1);
        chk("t1_rsv_valid", 64'(bus_if.rsv_valid), 64'd1);
        chk("t1_rsv_status", 64'(bus_if.rsv_status), 64'd0);
        chk("t1_rsv_rec", {bus_if.rsv_func_id, bus_if.rsv_token}, recs[0]);
        rsv_take();
        chk("t1_ok_cnt", 64'(ok_cnt), 64'd1);
        chk("t1_busy_idle", 64'(busy), 64'd0);

        // 2: three failed attempts -> status 01
        bus_if.irq_valid = 1'b1;
        tick();
        bus_if.irq_valid = 1'b0;
        wait_disp("t2_disp0");
        chk("t2_attempt0", 64'(bus_if.disp_attempt), 64'd0);
        tick();
        cpl(1'b0);
        chk("t2_redisp1", 64'(bus_if.disp_valid), 64'd1);
        chk("t2_attempt1", 64'(bus_if.disp_attempt), 64'd1);
        tick();
        cpl(1'b0);
        chk("t2_redisp2", 64'(bus_if.disp_valid), 64'd1);
        chk("t2_attempt2", 64'(bus_if.disp_attempt), 64'd2);
        tick();
        cpl(1'b0);
        chk("t2_no_redisp", 64'(bus_if.disp_valid), 64'd0);
        chk("t2_rsv_valid", 64'(bus_if.rsv_valid), 64'd1);
        chk("t2_rsv_status", 64'(bus_if.rsv_status), 64'd1);
        chk("t2_rsv_rec", {bus_if.rsv_func_id, bus_if.rsv_token}, recs[1]);
        rsv_take();
        chk("t2_err_cnt", 64'(err_cnt), 64'd1);
        chk("t2_ok_cnt", 64'(ok_cnt), 64'd1);

        // 3a: timeout 8 edges after the dispatch handshake
        bus_if.irq_valid = 1'b1;
        tick();
        bus_if.irq_valid = 1'b0;
        wait_disp("t3_disp");
        tick();
        n = 0;
        while (bus_if.rsv_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t3_tmo_latency", 64'(n), 64'd8);
        chk("t3_tmo_status", 64'(bus_if.rsv_status), 64'd2);
        chk("t3_tmo_disp", 64'(bus_if.disp_valid), 64'd0);
        rsv_take();
        chk("t3_err_cnt", 64'(err_cnt), 64'd2);

        // 3b: completion on the timeout cycle wins
        bus_if.irq_valid = 1'b1;
        tick();
        bus_if.irq_valid = 1'b0;
        wait_disp("t3b_disp");
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("t3b_pre_rsv", 64'(bus_if.rsv_valid), 64'd0);
        cpl(1'b1);
        chk("t3b_rsv_valid", 64'(bus_if.rsv_valid), 64'd1);
        chk("t3b_rsv_status", 64'(bus_if.rsv_status), 64'd0);
        chk("t3b_rsv_rec", {bus_if.rsv_func_id, bus_if.rsv_token}, recs[3]);
        rsv_take();
        chk("t3b_ok_cnt", 64'(ok_cnt), 64'd2);
        chk("t3b_err_cnt", 64'(err_cnt), 64'd2);

        // 4: three queued records, resolution back-pressured
        bus_if.irq_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_disp("t4_disp");
            tick();
            cpl(1'b1);
            chk("t4_rsv_valid", 64'(bus_if.rsv_valid), 64'd1);
            chk("t4_rsv_rec", {bus_if.rsv_func_id, bus_if.rsv_token},
                recs[4 + k]);
            snap = {bus_if.rsv_func_id, bus_if.rsv_token};
            for (int c = 0; c < 10; c++) begin
                tick();
                chk("t4_hold_valid", 64'(bus_if.rsv_valid), 64'd1);
                chk("t4_hold_rec", {bus_if.rsv_func_id, bus_if.rsv_token},
                    snap);
            end
            chk("t4_hold_pops", 64'(pops), 64'(5 + k));
            chk("t4_hold_hr", 64'(bus_if.host_ready), 64'd0);
            if (k == 2) bus_if.irq_valid = 1'b0;
            rsv_take();
        end
        tick();
        tick();
        chk("t4_total_pops", 64'(pops), 64'd7);
        chk("t4_idle", 64'(busy), 64'd0);
        chk("t4_ok_sat", 64'(ok_cnt), 64'd3);

        // 5: stray completions, then reset in WAIT_CPL
        cpl(1'b1);
        chk("t5_idle_stray_busy", 64'(busy), 64'd0);
        chk("t5_idle_stray_rsv", 64'(bus_if.rsv_valid), 64'd0);
        chk("t5_idle_stray_cnt", {ok_cnt, err_cnt}, 64'hE);
        bus_if.disp_ready = 1'b0;
        bus_if.irq_valid  = 1'b1;
        tick();
        bus_if.irq_valid  = 1'b0;
        wait_disp("t5_disp");
        cpl(1'b1);
        chk("t5_disp_stray_dv", 64'(bus_if.disp_valid), 64'd1);
        chk("t5_disp_stray_rsv", 64'(bus_if.rsv_valid), 64'd0);
        chk("t5_disp_stray_att", 64'(bus_if.disp_attempt), 64'd0);
        bus_if.disp_ready = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outs",
            {bus_if.host_ready, bus_if.disp_valid, bus_if.rsv_valid,
             busy, ok_cnt, err_cnt, bus_if.rsv_status}, 64'd0);
        chk("t5_rst_payload", {bus_if.rsv_func_id, bus_if.rsv_token}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_post_rsv", 64'(bus_if.rsv_valid), 64'd0);
        chk("t5_post_pops", 64'(pops), 64'd8);
        run_ok("t5_resume", recs[8]);
        chk("t5_ok_cnt", 64'(ok_cnt), 64'd1);
        chk("t5_pops", 64'(pops), 64'd9);

        // 6: ok counter saturates at 3 with CNT_W=2
        run_ok("t6_r0", recs[9]);
        chk("t6_ok2", 64'(ok_cnt), 64'd2);
        run_ok("t6_r1", recs[10]);
        run_ok("t6_r2", recs[11]);
        run_ok("t6_r3", recs[12]);
        chk("t6_ok_sat", 64'(ok_cnt), 64'd3);
        chk("t6_err", 64'(err_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
